prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time stage directly upstream of the processor core.
- Receives a byte stream (valid/ready) carrying a program image and writes 9-bit machine-code words into the instruction memory that the core's fetch stage reads.
- Holds the core in reset until the whole image has been written and its checksum verified, then releases it.
- Replaces the fixed instruction ROM with a loadable instruction RAM, addressed by the same D-bit program counter width.

Parameters:
- D, 12: instruction address width; it matches the core's program counter width. Capacity is 2**D words.
- W, 9: machine-code word width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  D  instruction memory write address.
- imem_data  output  W  instruction memory write data.
- core_reset  output  1  reset to the core. High until the load succeeds.
- load_done  output  1  image loaded and verified (sticky).
- load_err  output  1  image rejected (sticky).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, name reset; it is sampled only on the rising edge of clk.
- Reset values:
  - FSM in LEN_LO, word count 0, checksum accumulator 0.
  - in_ready=0 during the reset cycle.
  - imem_we=0, imem_addr=0, imem_data=0.
  - core_reset=1, load_done=0, load_err=0.
- Accept rule: a byte is accepted when in_valid && in_ready on a rising edge.
  - in_ready=1 in LEN_LO, LEN_HI, INS_LO, INS_HI, CSUM; it is 0 in DONE and ERR.
  - in_ready is combinational from state only and never depends on in_valid.
- Image format, little-endian:
  - len_lo, len_hi: the 16-bit word count N.
  - For each of N words: lo byte = word[7:0], hi byte = word[8] in bit 0, with bits 7:1 required to be 0.
  - Final byte: csum = XOR of every preceding byte in the image.
- FSM transitions, each taken on acceptance:
  - LEN_LO -> LEN_HI.
  - LEN_HI -> INS_LO if 1 <= N <= 2**D; otherwise -> ERR.
  - INS_LO -> INS_HI.
  - INS_HI -> ERR if any of bits 7:1 are nonzero (no write is issued). Otherwise a write is issued, the count increments, and the next state is CSUM if the count has reached N, else INS_LO.
  - CSUM -> DONE if the received byte equals the accumulator; otherwise -> ERR.
  - DONE and ERR are terminal until reset.
- Write timing (registered):
  - imem_we pulses for exactly one cycle, in the cycle after the hi byte is accepted.
  - imem_addr equals the word index (0 for the first word).
  - imem_data = {hi[0], lo}.
  - imem_addr and imem_data hold their last values when imem_we=0.
- Counter width: the word count is D+1 bits, so N=2**D completes without wrap-around. The last address written is 2**D-1.
- Checksum accumulator: XOR-updated on every accepted byte except the csum byte itself.
- DONE: core_reset falls and load_done rises in the cycle after csum acceptance; both then hold.
- ERR: load_err rises in the cycle after the offending byte is accepted; core_reset stays 1. Words already written remain in memory and are not erased.
- Stalls: in_valid=0 in any receiving state holds the state with no side effects, for any duration.
- Reset mid-load: a full restart at LEN_LO with core_reset reasserted immediately in the reset cycle. A partially written image is overwritten by the next load.
- Bytes presented in DONE or ERR are not accepted (in_ready=0).

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state enum {LEN_LO, LEN_HI, INS_LO, INS_HI, CSUM, DONE, ERR};
  - the image format constants (header byte count 2, hi-byte reserved mask 8'hFE).
- Single module; no sub-module is needed.
- The instruction RAM itself is a separate existing-style memory block and is not part of this block.

Test Plan:
- Nominal load: bytes 02 00 A5 01 03 00 A5 with in_valid continuously high.
  - Required: writes (addr 0, 9'h1A5) and then (addr 1, 9'h003).
  - core_reset falls and load_done=1 one cycle after the 7th byte is accepted.
- Checksum failure: the same image with a final byte of A4.
  - Required: both writes occur, load_err=1, core_reset stays 1, and in_ready=0 thereafter.
- Bad length: len bytes 00 00 (N=0), then separately 01 10 (N=4097).
  - Required: load_err=1 after len_hi in both cases, with no imem_we.
- Reserved bits: 01 00 12 02 ...
  - Required: ERR after the hi byte 02, with no write to addr 0.
- Stalls and reset mid-load:
  - Nominal image with in_valid dropped for 3 cycles between every byte: identical writes and outcome.
  - Assert reset after the first write, then reload a different 1-word image: that word is written at addr 0 and load_done=1.
- Capacity: N=4096 with all words 9'h1FF.
  - Required: 4096 writes at addr 0..4095, no wrap to 0, and load_done=1 after a correct csum.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-image loader: FSM states and the
// byte-level layout of the image stream.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        INS_LO,
        INS_HI,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int         HDR_BYTES    = 2;
    localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// 9-bit instruction words and holds the core in reset until it verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         imem_we,
    output logic [D-1:0] imem_addr,
    output logic [W-1:0] imem_data,
    output logic         core_reset,
    output logic         load_done,
    output logic         load_err
);

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_len_lo;
    logic [15:0]  r_len;
    logic [7:0]   r_lo;
    logic [7:0]   r_csum;
    logic [D:0]   r_cnt;
    logic         r_we;
    logic [D-1:0] r_addr;
    logic [W-1:0] r_data;
    logic         r_done;
    logic         r_err;

    logic         w_recv;
    logic         w_acc;
    logic [15:0]  w_n;
    logic         w_len_ok;
    logic         w_hi_ok;
    logic         w_last;

    assign w_recv   = (r_state != DONE) && (r_state != ERR);
    // Gated by reset so nothing looks accepted while the block restarts.
    assign in_ready = w_recv && !reset;
    assign w_acc    = in_valid && in_ready;
    assign w_n      = {in_data, r_len_lo};
    assign w_len_ok = (w_n != 16'd0) && (32'(w_n) <= (32'd1 << D));
    assign w_hi_ok  = (in_data & HI_RSVD_MASK) == 8'h00;
    assign w_last   = (32'(r_cnt) + 32'd1) == 32'(r_len);

    always_ff @(posedge clk) begin
        if (reset) r_state <= LEN_LO;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            case (r_state)
                LEN_LO:  w_next = LEN_HI;
                LEN_HI:  w_next = w_len_ok ? INS_LO : ERR;
                INS_LO:  w_next = INS_HI;
                INS_HI:  w_next = !w_hi_ok ? ERR : (w_last ? CSUM : INS_LO);
                CSUM:    w_next = (in_data == r_csum) ? DONE : ERR;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_lo     <= '0;
            r_csum   <= '0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= (w_next == DONE);
            r_err  <= (w_next == ERR);
            if (w_acc) begin
                // The checksum byte itself is compared, never folded in.
                if (r_state != CSUM) r_csum <= r_csum ^ in_data;
                case (r_state)
                    LEN_LO: r_len_lo <= in_data;
                    LEN_HI: r_len    <= w_n;
                    INS_LO: r_lo     <= in_data;
                    INS_HI: begin
                        if (w_hi_ok) begin
                            r_we   <= 1'b1;
                            r_addr <= r_cnt[D-1:0];
                            r_data <= W'({in_data[0], r_lo});
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_data  = r_data;
    // Reasserted combinationally so a mid-load reset holds the core at once.
    assign core_reset = reset || !r_done;
    assign load_done  = r_done;
    assign load_err   = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized image loads checked against a byte-level image
// parser model that predicts the writes and the final outcome.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int D = 12;
    localparam int W = 9;

    typedef logic [7:0] bq_t[$];

    logic         clk = 0;
    logic         reset = 1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 0;
    logic         in_ready;
    logic         imem_we;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic         core_reset;
    logic         load_done;
    logic         load_err;

    int n_chk = 0;
    int n_err = 0;

    bq_t img;
    int  act_a[$], act_d[$], exp_a[$], exp_d[$];
    bit  exp_done, exp_err;

    prog_loader #(.D(D), .W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_data(imem_data), .core_reset(core_reset),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (imem_we) begin
            act_a.push_back(int'(imem_addr));
            act_d.push_back(int'(imem_data));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parses the image as the stream format defines it.
    task automatic model();
        int n;
        logic [7:0] x, lo, hi;
        exp_a.delete(); exp_d.delete();
        exp_done = 0; exp_err = 0;
        n = int'({img[1], img[0]});
        x = img[0] ^ img[1];
        if (n == 0 || n > (1 << D)) begin exp_err = 1; return; end
        for (int i = 0; i < n; i++) begin
            lo = img[HDR_BYTES + 2*i];
            hi = img[HDR_BYTES + 2*i + 1];
            x = x ^ lo ^ hi;
            if (hi > 8'd1) begin exp_err = 1; return; end
            exp_a.push_back(i);
            exp_d.push_back(int'({hi[0], lo}));
        end
        if (img[HDR_BYTES + 2*n] == x) exp_done = 1;
        else                           exp_err = 1;
    endtask

    // mode 0: valid image, 1: corrupt checksum, 2: reserved bit set in one hi byte
    task automatic build(input int n, input bit ones, input int mode);
        logic [8:0] w;
        logic [7:0] lo, hi, x;
        int badw;
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        badw = (mode == 2) ? int'($urandom_range(n - 1, 0)) : -1;
        for (int i = 0; i < n; i++) begin
            w  = ones ? 9'h1FF : 9'($urandom);
            lo = w[7:0];
            hi = {7'b0, w[8]};
            if (i == badw) hi[$urandom_range(7, 1)] = 1'b1;
            img.push_back(lo);
            img.push_back(hi);
        end
        x = '0;
        foreach (img[i]) x = x ^ img[i];
        img.push_back(mode == 1 ? (x ^ 8'h5A) : x);
    endtask

    task automatic send(input int gap);
        for (int i = 0; i < img.size(); i++) begin
            @(negedge clk);
            if (!in_ready) break;
            in_valid = 1;
            in_data  = img[i];
            @(posedge clk); #1;
            if (gap > 0) begin
                in_valid = 0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; in_valid = 0;
        #1;
        chk("rst.ready", in_ready, 0);
        chk("rst.core_reset", core_reset, 1);
        @(negedge clk);
        reset = 0;
        act_a.delete(); act_d.delete();
    endtask

    task automatic run(input string tag, input int gap);
        int bad;
        model();
        act_a.delete(); act_d.delete();
        send(gap);
        chk({tag, ".done"}, load_done, exp_done);
        chk({tag, ".err"}, load_err, exp_err);
        chk({tag, ".core_reset"}, core_reset, !exp_done);
        chk({tag, ".ready"}, in_ready, !(exp_done || exp_err));
        // Offer more bytes in the terminal state; none must be taken.
        @(negedge clk);
        in_valid = 1; in_data = 8'h3C;
        repeat (3) @(negedge clk);
        in_valid = 0;
        chk({tag, ".hold_done"}, load_done, exp_done);
        chk({tag, ".hold_err"}, load_err, exp_err);
        chk({tag, ".nwr"}, act_a.size(), exp_a.size());
        bad = 0;
        for (int i = 0; i < act_a.size() && i < exp_a.size(); i++)
            if (act_a[i] != exp_a[i] || act_d[i] != exp_d[i]) bad++;
        chk({tag, ".wr"}, bad, 0);
    endtask

    initial begin
        bq_t nominal;
        nominal = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'hA5};

        repeat (2) @(negedge clk);
        chk("reset.ready", in_ready, 0);
        reset = 0;
        #1;
        chk("init.we", imem_we, 0);
        chk("init.addr", imem_addr, 0);
        chk("init.data", imem_data, 0);
        chk("init.core_reset", core_reset, 1);
        chk("init.done", load_done, 0);
        chk("init.err", load_err, 0);
        chk("init.ready", in_ready, 1);

        img = nominal;
        run("nominal", 0);
        chk("nominal.w0", act_d.size() > 0 ? act_d[0] : -1, 9'h1A5);
        chk("nominal.w1", act_d.size() > 1 ? act_d[1] : -1, 9'h003);
        chk("nominal.a1", act_a.size() > 1 ? act_a[1] : -1, 1);

        do_reset();
        img = nominal; img[6] = 8'hA4;
        run("badcsum", 0);

        do_reset();
        img = '{8'h00, 8'h00};
        run("len0", 0);

        do_reset();
        img = '{8'h01, 8'h10};
        run("len4097", 0);

        do_reset();
        img = '{8'h01, 8'h00, 8'h12, 8'h02, 8'h13};
        run("rsvd", 0);

        do_reset();
        img = nominal;
        run("stall", 3);

        do_reset();
        img = nominal[0:3];
        send(0);
        chk("midrst.nwr", act_a.size(), 1);
        chk("midrst.w0", act_d.size() > 0 ? act_d[0] : -1, 9'h1A5);
        do_reset();
        build(1, 0, 0);
        run("reload", 0);

        for (int k = 0; k < 8; k++) begin
            do_reset();
            build(int'($urandom_range(6, 1)), 0, int'($urandom_range(2, 0)));
            run($sformatf("rand%0d", k), int'($urandom_range(2, 0)));
        end

        do_reset();
        build(1 << D, 1, 0);
        run("capacity", 0);
        chk("capacity.last", act_a.size() > 0 ? act_a[act_a.size() - 1] : -1, (1 << D) - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
